// File: rtl/serial_to_parallel_rx.sv
// Single-lane receive deserializer: hunts for COM byte alignment bit by bit,
// confirms it over a train of aligned COMs, then delivers one byte per 8 clocks.
module serial_to_parallel_rx #(
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDL_SYM   = 8'h7C,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_LOCK,
        ST_ACTIVE
    } state_t;

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    state_t     r_state, w_state_next;
    // Only the seven most recent bits are kept; the incoming bit completes the byte.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [3:0] r_com_cnt, w_com_cnt_next;
    logic [7:0] r_data, w_data_next;
    logic       r_valid, w_valid_next;
    logic       r_strobe, w_strobe_next;
    logic       r_active, w_active_next;

    logic [7:0] w_byte;
    logic       w_is_com;
    logic       w_boundary;

    assign w_byte     = {r_sr, data_in};
    assign w_is_com   = (w_byte == COM_SYM);
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_com_cnt_next = r_com_cnt;
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_strobe_next  = 1'b0;
        w_active_next  = r_active;
        case (r_state)
            ST_SEARCH: begin
                if (w_is_com) begin
                    w_state_next   = ST_LOCK;
                    w_bit_cnt_next = 3'd0;
                    w_com_cnt_next = 4'd1;
                end
            end
            ST_LOCK: begin
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_com) begin
                        if (r_com_cnt + 4'd1 == COM_TARGET) begin
                            w_state_next   = ST_ACTIVE;
                            w_active_next  = 1'b1;
                            w_bit_cnt_next = 3'd0;
                            w_com_cnt_next = COM_TARGET;
                        end else begin
                            w_com_cnt_next = r_com_cnt + 4'd1;
                        end
                    end else begin
                        // A misaligned symbol drops the lock; this cycle is not re-hunted.
                        w_state_next   = ST_SEARCH;
                        w_com_cnt_next = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    w_data_next   = w_byte;
                    w_strobe_next = 1'b1;
                    w_valid_next  = (w_byte != COM_SYM) && (w_byte != IDL_SYM);
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            r_state   <= ST_SEARCH;
            r_sr      <= 7'd0;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sr      <= w_byte[6:0];
            r_bit_cnt <= w_bit_cnt_next;
            r_com_cnt <= w_com_cnt_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_strobe  <= w_strobe_next;
            r_active  <= w_active_next;
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;

endmodule
